// File: rtl/voice_scheduler.sv
// voice_scheduler: places song_reader notes on a bank of note_player voices, counts sustain per voice
// in beats, and stalls song_reader for rests. Build option VOICE_STEAL_EN enables voice stealing.
module voice_scheduler #(
  parameter int NUM_VOICES = 3,
  parameter int DUR_WIDTH  = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    play,
  input  logic                    beat,
  input  logic                    new_note,
  input  logic [5:0]              note,
  input  logic [DUR_WIDTH-1:0]    duration,
  output logic                    player_ready,
  output logic [NUM_VOICES-1:0]   voice_load,
  output logic [6*NUM_VOICES-1:0] voice_note,
  output logic [NUM_VOICES-1:0]   voice_active,
  output logic [NUM_VOICES-1:0]   voice_release,
  output logic                    note_dropped
);

  typedef enum logic [1:0] {IDLE = 2'd0, ALLOC = 2'd1, WAIT = 2'd2} state_t;

  state_t                                 state_r, state_next_s;
  logic                                   ready_r, ready_next_s;
  logic [DUR_WIDTH-1:0]                   wait_cnt_r;
  logic [NUM_VOICES-1:0][DUR_WIDTH-1:0]   remaining_r;
  logic [6*NUM_VOICES-1:0]                voice_note_r;
  logic [NUM_VOICES-1:0]                  voice_active_r, voice_load_r, voice_release_r;
  logic                                   note_dropped_r;
  logic                                   accept_s, tick_s, drop_s;
  logic [NUM_VOICES-1:0]                  load_sel_s, steal_rel_s;

  assign accept_s = new_note && ready_r && !clear;
  assign tick_s   = beat && play;

  function automatic logic [NUM_VOICES-1:0] pick_lowest(input logic [NUM_VOICES-1:0] free);
    logic [NUM_VOICES-1:0] sel;
    sel = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (free[i]) begin
        sel    = '0;
        sel[i] = 1'b1;
      end
    end
    return sel;
  endfunction

`ifdef VOICE_STEAL_EN
  // Victim is the active voice closest to expiry; strict compare keeps ties on the lowest index.
  function automatic logic [NUM_VOICES-1:0] pick_victim(
    input logic [NUM_VOICES-1:0]                act,
    input logic [NUM_VOICES-1:0][DUR_WIDTH-1:0] rem
  );
    logic [NUM_VOICES-1:0] sel;
    logic [DUR_WIDTH-1:0]  best;
    logic                  found;
    sel   = '0;
    best  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (act[i] && (!found || rem[i] < best)) begin
        sel    = '0;
        sel[i] = 1'b1;
        best   = rem[i];
        found  = 1'b1;
      end
    end
    return sel;
  endfunction
`endif

  // Voice allocation decision for the note accepted this cycle.
  always_comb begin
    load_sel_s  = '0;
    steal_rel_s = '0;
    drop_s      = 1'b0;
    if (accept_s && note != 6'd0) begin
      if (duration == '0) begin
        drop_s = 1'b1;
      end else if (|(~voice_active_r)) begin
        load_sel_s = pick_lowest(~voice_active_r);
      end else begin
`ifdef VOICE_STEAL_EN
        load_sel_s  = pick_victim(voice_active_r, remaining_r);
        steal_rel_s = load_sel_s;
`else
        drop_s = 1'b1;
`endif
      end
    end else begin
      drop_s = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      ready_r <= ready_next_s;
    end
  end

  // FSM next-state logic; clear overrides everything.
  always_comb begin
    state_next_s = state_r;
    if (clear) begin
      state_next_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s && note != 6'd0) begin
            state_next_s = ALLOC;
          end else if (accept_s && duration != '0) begin
            state_next_s = WAIT;
          end else begin
            state_next_s = IDLE;
          end
        end
        ALLOC: state_next_s = IDLE;
        WAIT: begin
          if (tick_s && wait_cnt_r <= {{(DUR_WIDTH-1){1'b0}}, 1'b1}) begin
            state_next_s = IDLE;
          end else begin
            state_next_s = WAIT;
          end
        end
        default: state_next_s = IDLE;
      endcase
    end
  end

  // Ready is registered from the next state so an accept drops it on the following cycle.
  always_comb begin
    ready_next_s = (state_next_s == IDLE) && play;
  end

  // Rest wait counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_r <= '0;
    end else if (clear) begin
      wait_cnt_r <= '0;
    end else if (state_r == IDLE && accept_s && note == 6'd0) begin
      wait_cnt_r <= duration;
    end else if (state_r == WAIT && tick_s && wait_cnt_r != '0) begin
      wait_cnt_r <= wait_cnt_r - {{(DUR_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Per-voice load, sustain countdown and release; a load beats a coincident decrement.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      remaining_r     <= '0;
      voice_note_r    <= '0;
      voice_active_r  <= '0;
      voice_load_r    <= '0;
      voice_release_r <= '0;
      note_dropped_r  <= 1'b0;
    end else if (clear) begin
      remaining_r     <= '0;
      voice_active_r  <= '0;
      voice_load_r    <= '0;
      voice_release_r <= '0;
      note_dropped_r  <= 1'b0;
    end else begin
      voice_load_r   <= load_sel_s;
      note_dropped_r <= drop_s;
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (load_sel_s[i]) begin
          remaining_r[i]       <= duration;
          voice_note_r[6*i +: 6] <= note;
          voice_active_r[i]    <= 1'b1;
          voice_release_r[i]   <= steal_rel_s[i];
        end else if (tick_s && voice_active_r[i] && remaining_r[i] != '0) begin
          remaining_r[i] <= remaining_r[i] - {{(DUR_WIDTH-1){1'b0}}, 1'b1};
          if (remaining_r[i] == {{(DUR_WIDTH-1){1'b0}}, 1'b1}) begin
            voice_active_r[i]  <= 1'b0;
            voice_release_r[i] <= 1'b1;
          end else begin
            voice_release_r[i] <= 1'b0;
          end
        end else begin
          voice_release_r[i] <= 1'b0;
        end
      end
    end
  end

  assign player_ready  = ready_r;
  assign voice_load    = voice_load_r;
  assign voice_note    = voice_note_r;
  assign voice_active  = voice_active_r;
  assign voice_release = voice_release_r;
  assign note_dropped  = note_dropped_r;

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler (3 voices); expectations follow the VOICE_STEAL_EN setting.
module tb_voice_scheduler;

  logic        clk = 1'b0;
  logic        reset, clear, play, beat, new_note;
  logic [5:0]  note;
  logic [5:0]  duration;
  logic        player_ready, note_dropped;
  logic [2:0]  voice_load, voice_active, voice_release;
  logic [17:0] voice_note;
  int          tests = 0;
  int          fails = 0;

  voice_scheduler #(.NUM_VOICES(3), .DUR_WIDTH(6)) dut (
    .clk(clk), .reset(reset), .clear(clear), .play(play), .beat(beat),
    .new_note(new_note), .note(note), .duration(duration),
    .player_ready(player_ready), .voice_load(voice_load), .voice_note(voice_note),
    .voice_active(voice_active), .voice_release(voice_release), .note_dropped(note_dropped)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a note for one cycle, then let ALLOC return to IDLE.
  task automatic send(input logic [5:0] n, input logic [5:0] d);
    note = n; duration = d; new_note = 1'b1;
    cyc();
    new_note = 1'b0;
  endtask

  task automatic pulse_beat();
    beat = 1'b1;
    cyc();
    beat = 1'b0;
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0; play = 1'b0; beat = 1'b0;
    new_note = 1'b0; note = 6'd0; duration = 6'd0;
    cyc(); cyc();
    check("rst_ready", {31'd0, player_ready}, 32'd0);
    check("rst_active", {29'd0, voice_active}, 32'd0);
    check("rst_note", {14'd0, voice_note}, 32'd0);
    check("rst_pulses", {26'd0, voice_load, voice_release}, 32'd0);
    check("rst_drop", {31'd0, note_dropped}, 32'd0);

    reset = 1'b1;
    cyc();
    check("ready_no_play", {31'd0, player_ready}, 32'd0);
    play = 1'b1;
    cyc();
    check("ready_after_play", {31'd0, player_ready}, 32'd1);

    // Three notes on three voices, all expiring together.
    send(6'd12, 6'd4);
    check("load0", {29'd0, voice_load}, 32'b001);
    check("ready_low_t1", {31'd0, player_ready}, 32'd0);
    cyc();
    check("ready_high_t2", {31'd0, player_ready}, 32'd1);
    check("load_pulse_end", {29'd0, voice_load}, 32'd0);
    send(6'd16, 6'd4);
    check("load1", {29'd0, voice_load}, 32'b010);
    cyc();
    send(6'd19, 6'd4);
    check("load2", {29'd0, voice_load}, 32'b100);
    check("active_all", {29'd0, voice_active}, 32'b111);
    check("notes_all", {14'd0, voice_note}, {14'd0, 6'd19, 6'd16, 6'd12});
    cyc();
    for (int i = 0; i < 3; i++) pulse_beat();
    check("active_3beats", {29'd0, voice_active}, 32'b111);
    check("rel_3beats", {29'd0, voice_release}, 32'd0);
    pulse_beat();
    check("rel_all", {29'd0, voice_release}, 32'b111);
    check("active_none", {29'd0, voice_active}, 32'd0);
    cyc();
    check("rel_pulse_end", {29'd0, voice_release}, 32'd0);

    // Rest of 3 beats stalls the reader; a note offered meanwhile is ignored.
    send(6'd0, 6'd3);
    check("rest_ready_low", {31'd0, player_ready}, 32'd0);
    pulse_beat();
    send(6'd5, 6'd3);
    check("ignored_load", {29'd0, voice_load}, 32'd0);
    check("ignored_active", {29'd0, voice_active}, 32'd0);
    pulse_beat();
    cyc();
    check("rest_ready_2beats", {31'd0, player_ready}, 32'd0);
    pulse_beat();
    check("rest_ready_back", {31'd0, player_ready}, 32'd1);
    check("rest_no_load", {29'd0, voice_load}, 32'd0);

    // All voices busy with 5,2,7 beats left.
    send(6'd30, 6'd5); cyc();
    send(6'd31, 6'd2); cyc();
    send(6'd32, 6'd7); cyc();
    send(6'd24, 6'd2);
`ifdef VOICE_STEAL_EN
    check("steal_drop", {31'd0, note_dropped}, 32'd0);
    check("steal_load", {29'd0, voice_load}, 32'b010);
    check("steal_rel", {29'd0, voice_release}, 32'b010);
    check("steal_notes", {14'd0, voice_note}, {14'd0, 6'd32, 6'd24, 6'd30});
`else
    check("full_drop", {31'd0, note_dropped}, 32'd1);
    check("full_load", {29'd0, voice_load}, 32'd0);
    check("full_notes", {14'd0, voice_note}, {14'd0, 6'd32, 6'd31, 6'd30});
`endif
    check("full_active", {29'd0, voice_active}, 32'b111);
    cyc();
    check("drop_pulse_end", {31'd0, note_dropped}, 32'd0);
    pulse_beat();
    pulse_beat();
    check("v1_expire", {29'd0, voice_release}, 32'b010);
    check("v1_expire_act", {29'd0, voice_active}, 32'b101);

    // Play low freezes counting: voice0 keeps its 3 beats.
    play = 1'b0;
    cyc();
    check("pause_ready", {31'd0, player_ready}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      pulse_beat();
      cyc();
    end
    check("pause_active", {29'd0, voice_active}, 32'b101);
    check("pause_rel", {29'd0, voice_release}, 32'd0);
    play = 1'b1;
    cyc();
    pulse_beat();
    pulse_beat();
    check("resume_2", {29'd0, voice_active}, 32'b101);
    pulse_beat();
    check("resume_rel", {29'd0, voice_release}, 32'b001);
    check("resume_act", {29'd0, voice_active}, 32'b100);
    cyc();

    // Voice0 expires on the same beat a note arrives: it is not free for that note.
    send(6'd40, 6'd1); cyc();
    send(6'd41, 6'd5); cyc();
    check("pre6_active", {29'd0, voice_active}, 32'b111);
    beat = 1'b1;
    send(6'd50, 6'd3);
    beat = 1'b0;
    check("coinc_rel", {29'd0, voice_release}, 32'b001);
`ifdef VOICE_STEAL_EN
    check("coinc_load", {29'd0, voice_load}, 32'b001);
    check("coinc_act", {29'd0, voice_active}, 32'b111);
    check("coinc_drop", {31'd0, note_dropped}, 32'd0);
`else
    check("coinc_load", {29'd0, voice_load}, 32'd0);
    check("coinc_act", {29'd0, voice_active}, 32'b110);
    check("coinc_drop", {31'd0, note_dropped}, 32'd1);
`endif
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    check("clear_act", {29'd0, voice_active}, 32'd0);
    check("clear_pulses", {26'd0, voice_load, voice_release}, 32'd0);
    pulse_beat();
    check("post_clear_rel", {29'd0, voice_release}, 32'd0);
    check("post_clear_ready", {31'd0, player_ready}, 32'd1);

    // Zero-duration note is dropped; zero-duration rest does not stall.
    send(6'd9, 6'd0);
    check("d0_drop", {31'd0, note_dropped}, 32'd1);
    check("d0_load", {29'd0, voice_load}, 32'd0);
    cyc();
    send(6'd0, 6'd0);
    check("rest0_ready", {31'd0, player_ready}, 32'd1);

    // Async reset in the middle of a rest with two voices sounding.
    send(6'd1, 6'd9); cyc();
    send(6'd2, 6'd9); cyc();
    send(6'd0, 6'd5);
    pulse_beat();
    check("midwait_act", {29'd0, voice_active}, 32'b011);
    #2;
    reset = 1'b0;
    play  = 1'b0;
    #1;
    check("async_ready", {31'd0, player_ready}, 32'd0);
    check("async_act", {29'd0, voice_active}, 32'd0);
    check("async_note", {14'd0, voice_note}, 32'd0);
    reset = 1'b1;
    cyc();
    check("rel_ready_noplay", {31'd0, player_ready}, 32'd0);
    play = 1'b1;
    cyc();
    check("rel_ready_play", {31'd0, player_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
